commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
Synthesizable, parametrised successor to the single-port bench-side commit tracer. It captures retire events from up to NUM_PORTS commit slots per cycle and numbers them in program order. Events are buffered in a FIFO and drained over a valid/ready stream to a trace sink (bench logger or debug port). It tracks cycle and instruction counts, handles halt, and flags overflow.

Parameters:
NUM_PORTS, 1, number of commit slots per cycle (legal values 1 or 2)
DEPTH, 16, FIFO entries (power of 2, >= 4)
CNT_W, 32, width of the instruction-number and cycle counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cm_valid  input  NUM_PORTS  per-slot commit valid; slot 0 is older
cm_pc  input  16*NUM_PORTS  PC of committing instruction
cm_regwr  input  NUM_PORTS  register write
cm_reg  input  3*NUM_PORTS  destination register
cm_wdata  input  16*NUM_PORTS  register write data
cm_memrd  input  NUM_PORTS  memory read
cm_memwr  input  NUM_PORTS  memory write
cm_addr  input  16*NUM_PORTS  memory address
cm_mdata  input  16*NUM_PORTS  memory store data
cm_halt  input  NUM_PORTS  halt committing
out_valid  output  1  trace record available
out_ready  input  1  sink accepts record
out_inum  output  CNT_W  instruction number (0-based)
out_pc  output  16  record PC
out_flags  output  4  {halt, memwr, memrd, regwr}
out_reg  output  3  destination register
out_wdata  output  16  register write data
out_addr  output  16  memory address
out_mdata  output  16  store data
cycle_count  output  CNT_W  cycles since reset
inst_count  output  CNT_W  instructions numbered so far
overflow  output  1  sticky; at least one cycle's commits were dropped
drop_count  output  16  number of dropped commits, saturating at 0xFFFF
halted  output  1  halt captured and FIFO fully drained

Behaviour:
- Reset: all outputs are 0, the FIFO is empty, and state = RUN. Reset mid-drain discards all FIFO contents.
- cycle_count increments every non-reset cycle and wraps modulo 2^CNT_W.
- Enqueue, state RUN:
  - Valid slots are written in slot order (slot 0 first) in the same cycle; k = popcount(cm_valid).
  - Each written entry gets inum = inst_count + its index among the valid slots. inst_count += k.
  - Capture is all-or-nothing per cycle. If free entries < k, the cycle writes no entries, inst_count still advances by k, overflow is set, and drop_count += k (saturating).
  - Free-entry count includes an entry popped in the same cycle: pop happens first, then the space check.
- Halt:
  - If a captured slot has cm_halt = 1, the state goes to HALTED next cycle.
  - In the same cycle, any slot younger than the halt slot is ignored: not written, not numbered.
  - In HALTED, all cm_valid is ignored.
  - HALTED moves to DONE when the FIFO is empty. halted = 1 in DONE only. DONE persists until rst.
  - A dropped halt (overflow) still moves the state to HALTED.
- Dequeue:
  - out_valid = FIFO not empty. The out_* fields show the head entry combinationally from storage.
  - A pop occurs when out_valid && out_ready.
  - The out_* fields are stable while out_valid = 1 and out_ready = 0.
- Latency: a commit on cycle N appears on out_* at cycle N+1 when the FIFO was empty. Throughput is one record per cycle out and up to NUM_PORTS in.
- Pointers: log2(DEPTH)+1 bits. Full when the low bits are equal and the MSBs differ. Pointers wrap modulo 2·DEPTH.
- Simultaneous push and pop when full: the pop frees one entry for that cycle's check, so a single commit is accepted.

Optional Feature:
TRACE_FILTER_NOP_EN:
- When defined, a commit with regwr = memwr = halt = 0 (branch or NOP) is numbered (inst_count advances) but is not written to the FIFO. It needs no space and never causes overflow.
- When undefined, all commits are written.

Test Plan:
- NUM_PORTS=1, DEPTH=4, out_ready=1. Commit PC 0x0000, 0x0002, 0x0004 on consecutive cycles -> records inum 0,1,2 appear one cycle after each commit with matching PC; inst_count = 3.
- NUM_PORTS=2, out_ready=0. Commit both slots for 2 cycles -> 4 entries, inum 0..3 in slot order. A third dual commit -> overflow = 1, drop_count = 2, inst_count = 6, FIFO still holds inum 0..3.
- Full FIFO (DEPTH=4), out_ready=1, one commit in the same cycle -> accepted, overflow stays 0, occupancy stays 4.
- Dual commit with slot 0 halt = 1, slot 1 valid -> only slot 0 captured; inst_count += 1; later commits ignored. Drain -> halted = 1 in the cycle after the last pop.
- Assert rst with 3 entries queued -> next cycle out_valid = 0, counters 0, state RUN. A new commit gets inum 0.
- TRACE_FILTER_NOP_EN defined: commit a NOP then addi r1 -> only one record, inum 1, reg 1.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: numbers retiring instructions in program order, queues them in a FIFO
// and drains them over a valid/ready stream. Optional macro TRACE_FILTER_NOP_EN drops NOP/branch records.
module commit_trace_buffer #(
  parameter int NUM_PORTS = 1,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    cm_valid,
  input  logic [16*NUM_PORTS-1:0] cm_pc,
  input  logic [NUM_PORTS-1:0]    cm_regwr,
  input  logic [3*NUM_PORTS-1:0]  cm_reg,
  input  logic [16*NUM_PORTS-1:0] cm_wdata,
  input  logic [NUM_PORTS-1:0]    cm_memrd,
  input  logic [NUM_PORTS-1:0]    cm_memwr,
  input  logic [16*NUM_PORTS-1:0] cm_addr,
  input  logic [16*NUM_PORTS-1:0] cm_mdata,
  input  logic [NUM_PORTS-1:0]    cm_halt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        out_inum,
  output logic [15:0]             out_pc,
  output logic [3:0]              out_flags,
  output logic [2:0]              out_reg,
  output logic [15:0]             out_wdata,
  output logic [15:0]             out_addr,
  output logic [15:0]             out_mdata,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        inst_count,
  output logic                    overflow,
  output logic [15:0]             drop_count,
  output logic                    halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = CNT_W + 16 + 4 + 3 + 16 * 3;

  typedef enum logic [1:0] {RUN, HALTED, DONE} state_t;

  state_t         state, stateNext;
  logic [PW-1:0]  wrPtr, rdPtr;
  logic [PW-1:0]  occupancy;
  logic [PW:0]    freeSlots;
  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  headEntry;
  logic           pop, accept, haltHit, keep;
  logic [1:0]     numCnt, storeCnt;
  logic [16:0]    dropSum;
  logic [NUM_PORTS-1:0] stored;
  logic [AW-1:0]  slotAddr  [NUM_PORTS];
  logic [EW-1:0]  slotEntry [NUM_PORTS];

  assign occupancy = wrPtr - rdPtr;
  assign out_valid = (wrPtr != rdPtr);
  assign pop       = out_valid && out_ready;
  // Space check sees the entry popped this cycle as already free.
  assign freeSlots = (PW+1)'(DEPTH) - {1'b0, occupancy} + {{PW{1'b0}}, pop};
  assign accept    = ({{(PW-1){1'b0}}, storeCnt} <= freeSlots);
  assign dropSum   = {1'b0, drop_count} + 17'(storeCnt);
  assign headEntry = mem[rdPtr[AW-1:0]];
  assign halted    = (state == DONE);

  assign {out_inum, out_pc, out_flags, out_reg, out_wdata, out_addr, out_mdata} =
    out_valid ? headEntry : '0;

  // Slot selection: walk slots oldest first, stop numbering after a halt.
  always_comb begin
    haltHit  = 1'b0;
    numCnt   = 2'd0;
    storeCnt = 2'd0;
    keep     = 1'b0;
    stored   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      slotAddr[i]  = '0;
      slotEntry[i] = '0;
    end
    if (state == RUN) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cm_valid[i] && !haltHit) begin
`ifdef TRACE_FILTER_NOP_EN
          keep = cm_regwr[i] | cm_memwr[i] | cm_halt[i];
`else
          keep = 1'b1;
`endif
          slotEntry[i] = {inst_count + CNT_W'(numCnt), cm_pc[16*i +: 16],
                          cm_halt[i], cm_memwr[i], cm_memrd[i], cm_regwr[i],
                          cm_reg[3*i +: 3], cm_wdata[16*i +: 16],
                          cm_addr[16*i +: 16], cm_mdata[16*i +: 16]};
          numCnt = numCnt + 2'd1;
          if (keep) begin
            stored[i]   = 1'b1;
            slotAddr[i] = wrPtr[AW-1:0] + AW'(storeCnt);
            storeCnt    = storeCnt + 2'd1;
          end
          if (cm_halt[i]) haltHit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (haltHit) stateNext = HALTED;
      HALTED:  if (occupancy == PW'(pop)) stateNext = DONE;
      default: stateNext = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= stateNext;
  end

  // A rejected cycle still numbers its commits so the sink can see the gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      cycle_count <= '0;
      inst_count  <= '0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      cycle_count <= cycle_count + 1'b1;
      inst_count  <= inst_count + CNT_W'(numCnt);
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (accept) begin
        wrPtr <= wrPtr + PW'(storeCnt);
      end else begin
        overflow   <= 1'b1;
        drop_count <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!rst && accept && stored[i]) mem[slotAddr[i]] <= slotEntry[i];
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer (two commit slots, four-entry FIFO).
module tb_commit_trace_buffer;

  localparam int NP = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] cm_valid, cm_regwr, cm_memrd, cm_memwr, cm_halt;
  logic [16*NP-1:0] cm_pc, cm_wdata, cm_addr, cm_mdata;
  logic [3*NP-1:0]  cm_reg;
  logic          out_valid, out_ready;
  logic [CW-1:0] out_inum, cycle_count, inst_count;
  logic [15:0]   out_pc, out_wdata, out_addr, out_mdata, drop_count;
  logic [3:0]    out_flags;
  logic [2:0]    out_reg;
  logic          overflow, halted;
  int            checks = 0;
  int            errors = 0;

  commit_trace_buffer #(.NUM_PORTS(NP), .DEPTH(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_regwr(cm_regwr),
    .cm_reg(cm_reg), .cm_wdata(cm_wdata), .cm_memrd(cm_memrd), .cm_memwr(cm_memwr),
    .cm_addr(cm_addr), .cm_mdata(cm_mdata), .cm_halt(cm_halt), .out_valid(out_valid),
    .out_ready(out_ready), .out_inum(out_inum), .out_pc(out_pc), .out_flags(out_flags),
    .out_reg(out_reg), .out_wdata(out_wdata), .out_addr(out_addr), .out_mdata(out_mdata),
    .cycle_count(cycle_count), .inst_count(inst_count), .overflow(overflow),
    .drop_count(drop_count), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    cm_valid = '0; cm_pc = '0; cm_regwr = '0; cm_reg = '0; cm_wdata = '0;
    cm_memrd = '0; cm_memwr = '0; cm_addr = '0; cm_mdata = '0; cm_halt = '0;
  endtask

  // flags are {halt, memwr, memrd, regwr}; addr and store data derive from pc and wdata
  task automatic setSlot(input int s, input logic [15:0] pc, input logic [3:0] f,
                         input logic [2:0] r, input logic [15:0] wd);
    cm_valid[s] = 1'b1;
    cm_pc[16*s +: 16] = pc;
    cm_halt[s] = f[3]; cm_memwr[s] = f[2]; cm_memrd[s] = f[1]; cm_regwr[s] = f[0];
    cm_reg[3*s +: 3] = r;
    cm_wdata[16*s +: 16] = wd;
    cm_addr[16*s +: 16] = pc + 16'h0100;
    cm_mdata[16*s +: 16] = ~wd;
  endtask

  task automatic doReset();
    rst = 1'b1; out_ready = 1'b0; clearInputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; clearInputs();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_cycle got %0d exp 0", cycle_count); end
    checks++; if (inst_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_inst got %0d exp 0", inst_count); end
    checks++; if ({overflow, halted, drop_count} !== 18'd0) begin errors++; $display("[TB] FAIL reset_flags got %0b %0b %h exp 0", overflow, halted, drop_count); end
    checks++; if (out_pc !== 16'h0) begin errors++; $display("[TB] FAIL reset_pc got %h exp 0", out_pc); end
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("[TB] FAIL cycle_count got %0d exp 3", cycle_count); end
  endtask

  task automatic test_single();
    logic [15:0] pcs [3];
    pcs[0] = 16'h0000; pcs[1] = 16'h0002; pcs[2] = 16'h0004;
    doReset();
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      clearInputs();
      setSlot(0, pcs[j], 4'b0001, 3'(j + 2), 16'hAA00 + 16'(j));
      tick();
      checks++; if (out_valid !== 1'b1 || out_inum !== 32'(j) || out_pc !== pcs[j]) begin errors++; $display("[TB] FAIL single_rec%0d got v=%0b inum=%0d pc=%h exp v=1 inum=%0d pc=%h", j, out_valid, out_inum, out_pc, j, pcs[j]); end
    end
    checks++; if (out_reg !== 3'd4 || out_wdata !== 16'hAA02 || out_flags !== 4'b0001) begin errors++; $display("[TB] FAIL single_fields got reg=%0d wd=%h fl=%b exp reg=4 wd=AA02 fl=0001", out_reg, out_wdata, out_flags); end
    checks++; if (out_addr !== 16'h0104 || out_mdata !== 16'h55FD) begin errors++; $display("[TB] FAIL single_mem got addr=%h md=%h exp 0104 55FD", out_addr, out_mdata); end
    checks++; if (inst_count !== 32'd3) begin errors++; $display("[TB] FAIL single_inst got %0d exp 3", inst_count); end
    clearInputs();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_empty got %0b exp 0", out_valid); end
  endtask

  task automatic test_dual_overflow();
    doReset();
    setSlot(0, 16'h0010, 4'b0001, 3'd1, 16'h1111);
    setSlot(1, 16'h0012, 4'b0001, 3'd2, 16'h2222);
    tick();
    clearInputs();
    setSlot(0, 16'h0014, 4'b0010, 3'd3, 16'h3333);
    setSlot(1, 16'h0016, 4'b0100, 3'd4, 16'h4444);
    tick();
    checks++; if (inst_count !== 32'd4 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL dual_fill got inst=%0d ovf=%0b exp 4 0", inst_count, overflow); end
    clearInputs();
    setSlot(0, 16'h0018, 4'b0001, 3'd5, 16'h5555);
    setSlot(1, 16'h001A, 4'b0001, 3'd6, 16'h6666);
    tick();
    checks++; if (overflow !== 1'b1 || drop_count !== 16'd2) begin errors++; $display("[TB] FAIL dual_drop got ovf=%0b drop=%0d exp 1 2", overflow, drop_count); end
    checks++; if (inst_count !== 32'd6) begin errors++; $display("[TB] FAIL dual_inst got %0d exp 6", inst_count); end
    clearInputs();
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++; if (out_valid !== 1'b1 || out_inum !== 32'(j) || out_pc !== 16'h0010 + 16'(2*j)) begin errors++; $display("[TB] FAIL dual_rec%0d got v=%0b inum=%0d pc=%h exp v=1 inum=%0d pc=%h", j, out_valid, out_inum, out_pc, j, 16'h0010 + 16'(2*j)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dual_empty got %0b exp 0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] pcs [3];
    pcs[0] = 16'h0024; pcs[1] = 16'h0026; pcs[2] = 16'h0040;
    doReset();
    setSlot(0, 16'h0020, 4'b0001, 3'd1, 16'h0);
    setSlot(1, 16'h0022, 4'b0001, 3'd1, 16'h0);
    tick();
    clearInputs();
    setSlot(0, 16'h0024, 4'b0001, 3'd1, 16'h0);
    setSlot(1, 16'h0026, 4'b0001, 3'd1, 16'h0);
    tick();
    clearInputs();
    out_ready = 1'b1;
    setSlot(0, 16'h0040, 4'b0001, 3'd7, 16'h0);
    tick();
    checks++; if (overflow !== 1'b0 || inst_count !== 32'd5 || out_inum !== 32'd1) begin errors++; $display("[TB] FAIL full_accept got ovf=%0b inst=%0d inum=%0d exp 0 5 1", overflow, inst_count, out_inum); end
    clearInputs();
    setSlot(0, 16'h0050, 4'b0001, 3'd1, 16'h0);
    setSlot(1, 16'h0052, 4'b0001, 3'd1, 16'h0);
    tick();
    checks++; if (overflow !== 1'b1 || drop_count !== 16'd2 || inst_count !== 32'd7) begin errors++; $display("[TB] FAIL full_dual_drop got ovf=%0b drop=%0d inst=%0d exp 1 2 7", overflow, drop_count, inst_count); end
    clearInputs();
    for (int j = 0; j < 3; j++) begin
      checks++; if (out_valid !== 1'b1 || out_inum !== 32'(j + 2) || out_pc !== pcs[j]) begin errors++; $display("[TB] FAIL full_rec%0d got v=%0b inum=%0d pc=%h exp v=1 inum=%0d pc=%h", j, out_valid, out_inum, out_pc, j + 2, pcs[j]); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_empty got %0b exp 0", out_valid); end
  endtask

  task automatic test_halt();
    doReset();
    setSlot(0, 16'h0050, 4'b1000, 3'd0, 16'h0);
    setSlot(1, 16'h0052, 4'b0001, 3'd3, 16'h9);
    tick();
    checks++; if (inst_count !== 32'd1 || out_inum !== 32'd0 || out_pc !== 16'h0050 || out_flags !== 4'b1000) begin errors++; $display("[TB] FAIL halt_capture got inst=%0d inum=%0d pc=%h fl=%b exp 1 0 0050 1000", inst_count, out_inum, out_pc, out_flags); end
    clearInputs();
    setSlot(0, 16'h0054, 4'b0001, 3'd1, 16'h0);
    tick();
    checks++; if (inst_count !== 32'd1 || halted !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL halt_ignore got inst=%0d halted=%0b v=%0b exp 1 0 1", inst_count, halted, out_valid); end
    clearInputs();
    out_ready = 1'b1;
    tick();
    checks++; if (halted !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_done got halted=%0b v=%0b exp 1 0", halted, out_valid); end
    setSlot(0, 16'h0056, 4'b0001, 3'd1, 16'h0);
    tick();
    checks++; if (halted !== 1'b1 || inst_count !== 32'd1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_sticky got halted=%0b inst=%0d v=%0b exp 1 1 0", halted, inst_count, out_valid); end
    clearInputs();
  endtask

  task automatic test_reset_mid();
    doReset();
    setSlot(0, 16'h0060, 4'b0001, 3'd1, 16'h0);
    setSlot(1, 16'h0062, 4'b0001, 3'd1, 16'h0);
    tick();
    clearInputs();
    setSlot(0, 16'h0064, 4'b0001, 3'd1, 16'h0);
    tick();
    clearInputs();
    setSlot(0, 16'h0066, 4'b0001, 3'd1, 16'h0);
    setSlot(1, 16'h0068, 4'b0001, 3'd1, 16'h0);
    tick();
    checks++; if (overflow !== 1'b1 || drop_count !== 16'd2 || inst_count !== 32'd5) begin errors++; $display("[TB] FAIL mid_pre got ovf=%0b drop=%0d inst=%0d exp 1 2 5", overflow, drop_count, inst_count); end
    clearInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || inst_count !== 32'd0 || cycle_count !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset got v=%0b inst=%0d cyc=%0d exp 0 0 0", out_valid, inst_count, cycle_count); end
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_flags got ovf=%0b drop=%0d halted=%0b exp 0 0 0", overflow, drop_count, halted); end
    setSlot(0, 16'h0070, 4'b0001, 3'd2, 16'h0);
    tick();
    clearInputs();
    checks++; if (out_valid !== 1'b1 || out_inum !== 32'd0 || out_pc !== 16'h0070) begin errors++; $display("[TB] FAIL mid_new got v=%0b inum=%0d pc=%h exp 1 0 0070", out_valid, out_inum, out_pc); end
  endtask

  task automatic test_nop();
    doReset();
    setSlot(0, 16'h0080, 4'b0000, 3'd0, 16'h0);
    tick();
    clearInputs();
    setSlot(0, 16'h0082, 4'b0001, 3'd1, 16'h0001);
    tick();
    clearInputs();
    checks++; if (inst_count !== 32'd2) begin errors++; $display("[TB] FAIL nop_inst got %0d exp 2", inst_count); end
`ifndef TRACE_FILTER_NOP_EN
    checks++; if (out_valid !== 1'b1 || out_inum !== 32'd0 || out_pc !== 16'h0080) begin errors++; $display("[TB] FAIL nop_rec got v=%0b inum=%0d pc=%h exp 1 0 0080", out_valid, out_inum, out_pc); end
    out_ready = 1'b1;
    tick();
`endif
    checks++; if (out_valid !== 1'b1 || out_inum !== 32'd1 || out_reg !== 3'd1) begin errors++; $display("[TB] FAIL addi_rec got v=%0b inum=%0d reg=%0d exp 1 1 1", out_valid, out_inum, out_reg); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL nop_empty got %0b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual_overflow();
    test_full_push_pop();
    test_halt();
    test_reset_mid();
    test_nop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
